// File: rtl/spi_master_param.sv
// Parametrised full-duplex SPI master: configurable word width, slave count and SCLK
// divider, all four CPOL/CPHA modes, MSB/LSB-first order, start/busy/done handshake.
module spi_master_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N_CS   = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned DIV    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              sclk,
  output logic              mosi,
  output logic [N_CS-1:0]   cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done
);
  localparam int unsigned   CW        = $clog2(DIV + 1);
  localparam int unsigned   EW        = $clog2(2 * DATA_W);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_XFER,
    S_TRAIL,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     div_cnt_q, div_cnt_d;
  logic [EW-1:0]     edge_cnt_q, edge_cnt_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cpol_q, cpol_d;
  logic              cpha_q, cpha_d;
  logic              lsb_q, lsb_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              accept, tick, leading, sample, advance;
  logic [N_CS-1:0]   sel_onehot;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    edge_cnt_d = edge_cnt_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    sel_d      = sel_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;

    accept  = start && (state_q == S_IDLE || state_q == S_DONE) && (32'(sel) < N_CS);
    tick    = (div_cnt_q == DIV_LAST);
    // edge_cnt_q holds edges already produced, so an even count means the next edge leads
    leading = ~edge_cnt_q[0];
    sample  = leading ^ cpha_q;
    advance = cpha_q ? (leading && edge_cnt_q != '0) : (!leading && edge_cnt_q != EDGE_LAST);

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (accept) begin
          state_d    = S_LEAD;
          div_cnt_d  = '0;
          edge_cnt_d = '0;
          cpol_d     = cpol;
          cpha_d     = cpha;
          lsb_d      = lsb_first;
          sel_d      = sel;
          sclk_d     = cpol;
          tx_sh_d    = tx_data;
          rx_sh_d    = '0;
          mosi_d     = lsb_first ? tx_data[0] : tx_data[DATA_W-1];
        end
      end
      S_LEAD: begin
        if (tick) begin
          div_cnt_d = '0;
          state_d   = S_XFER;
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      S_XFER: begin
        if (tick) begin
          div_cnt_d  = '0;
          sclk_d     = ~sclk_q;
          edge_cnt_d = edge_cnt_q + EW'(1);
          if (sample) begin
            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]} : {rx_sh_q[DATA_W-2:0], miso};
          end
          if (advance) begin
            tx_sh_d = lsb_q ? (tx_sh_q >> 1) : (tx_sh_q << 1);
            mosi_d  = lsb_q ? tx_sh_d[0] : tx_sh_d[DATA_W-1];
          end
          if (edge_cnt_q == EDGE_LAST) begin
            state_d = S_TRAIL;
          end
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      S_TRAIL: begin
        if (tick) begin
          div_cnt_d = '0;
          state_d   = S_DONE;
          rx_data_d = rx_sh_q;
        end else begin
          div_cnt_d = div_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      edge_cnt_q <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      sel_q      <= '0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      sel_q      <= sel_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
    end
  end

  always_comb begin
    busy       = (state_q == S_LEAD) || (state_q == S_XFER) || (state_q == S_TRAIL);
    done       = (state_q == S_DONE);
    sel_onehot = N_CS'(1) << sel_q;
    cs_n       = busy ? ~sel_onehot : '1;
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign rx_data = rx_data_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: a default instance and a 16-bit/4-slave/DIV=1
// instance, each checked against a cycle-counting SPI slave model kept in the bench.
module tb_spi_master_param;
  logic        clk = 1'b0;
  logic        rst;
  logic        start, cpol, cpha, lsb_first;
  logic [1:0]  sel;
  logic [15:0] tx;
  logic        which, loop, slv_miso;

  logic        sclk_a, mosi_a, busy_a, done_a, miso_a, start_a;
  logic [2:0]  cs_a;
  logic [7:0]  rx_a;
  logic        sclk_b, mosi_b, busy_b, done_b, miso_b, start_b;
  logic [3:0]  cs_b;
  logic [15:0] rx_b;

  logic        sclk_c, mosi_c, busy_c, done_c;
  logic [3:0]  cs_c;
  logic [15:0] rx_c;

  int          n_checks, n_fail;
  logic        lpa, lpb;

  always #5 clk = ~clk;

  assign start_a = start & ~which;
  assign start_b = start & which;
  assign miso_a  = loop ? mosi_a : slv_miso;
  assign miso_b  = loop ? mosi_b : slv_miso;
  assign sclk_c  = which ? sclk_b : sclk_a;
  assign mosi_c  = which ? mosi_b : mosi_a;
  assign busy_c  = which ? busy_b : busy_a;
  assign done_c  = which ? done_b : done_a;
  assign cs_c    = which ? cs_b : {1'b1, cs_a};
  assign rx_c    = which ? rx_b : {8'h00, rx_a};

  spi_master_param #(.DATA_W(8), .N_CS(3), .SEL_W(2), .DIV(2)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .sel(sel), .tx_data(tx[7:0]), .miso(miso_a), .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_a),
    .rx_data(rx_a), .busy(busy_a), .done(done_a)
  );

  spi_master_param #(.DATA_W(16), .N_CS(4), .SEL_W(2), .DIV(1)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first),
    .sel(sel), .tx_data(tx), .miso(miso_b), .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_b),
    .rx_data(rx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // mode: 0 plain, 1 foreign start pulse mid-transfer, 2 start held across DONE (loopback only)
  task automatic run_xfer(input logic w, input logic pol, input logic pha, input logic lsbf,
                          input logic [1:0] s, input logic [15:0] data_in,
                          input logic [15:0] sword_in, input logic lb, input int mode);
    int          nbits, dv, done_t, done_at, n_done, edges, cn, sd;
    logic [15:0] data, swd, cap, exp_rx, tmp;
    logic [3:0]  cs_exp;
    logic        prev, lead_e, cs_ok;
    nbits   = w ? 16 : 8;
    dv      = w ? 1 : 2;
    done_t  = 2 * dv + 2 * nbits * dv;
    data    = w ? data_in : (data_in & 16'h00FF);
    swd     = w ? sword_in : (sword_in & 16'h00FF);
    exp_rx  = lb ? data : swd;
    cs_exp  = ~(4'b0001 << s);
    done_at = -1;
    n_done  = 0;
    edges   = 0;
    cn      = 0;
    cap     = '0;
    cs_ok   = 1'b1;

    @(negedge clk);
    which = w;
    #1;
    check_eq("sclk_pre", 32'(sclk_c), 32'(w ? lpb : lpa));
    cpol = pol; cpha = pha; lsb_first = lsbf; sel = s; tx = data; loop = lb; start = 1'b1;
    tmp      = swd >> (lsbf ? 0 : nbits - 1);
    slv_miso = tmp[0];
    sd       = pha ? 0 : 1;
    prev     = pol;
    @(posedge clk);
    for (int t = 0; t < done_t + 4; t++) begin
      @(negedge clk);
      if (t == 0) begin
        check_eq("sclk_lead", 32'(sclk_c), 32'(pol));
        prev  = sclk_c;
        start = (mode == 2);
      end
      if (sclk_c !== prev) begin
        edges++;
        lead_e = (edges % 2) == 1;
        if (lead_e ^ pha) begin
          if (cn < nbits) cap = cap | (16'(mosi_c) << (lsbf ? cn : nbits - 1 - cn));
          cn++;
        end else if (sd < nbits) begin
          tmp      = swd >> (lsbf ? sd : nbits - 1 - sd);
          slv_miso = tmp[0];
          sd++;
        end
        prev = sclk_c;
      end
      if (t < done_t && (cs_c !== cs_exp || busy_c !== 1'b1 || done_c !== 1'b0)) cs_ok = 1'b0;
      if (done_c === 1'b1) begin
        n_done++;
        if (done_at < 0) done_at = t;
        if (busy_c !== 1'b0) cs_ok = 1'b0;
      end
      if (mode == 1 && t == 12) begin
        start = 1'b1;
        sel   = (s == 2'd2) ? 2'd0 : 2'd2;
        tx    = ~data;
      end
      if (mode == 1 && t == 13) begin
        start = 1'b0;
        sel   = s;
        tx    = data;
      end
      if (mode == 2 && t == done_t) check_eq("cs_gap", 32'(cs_c), 32'hF);
      if (mode == 2 && t == done_t + 1) begin
        check_eq("b2b_lead", 32'(cs_c), 32'(cs_exp));
        start = 1'b0;
        break;
      end
    end
    check_eq("done_time", 32'(done_at), 32'(done_t));
    check_eq("done_count", 32'(n_done), 32'd1);
    check_eq("sclk_edges", 32'(edges), 32'(2 * nbits));
    check_eq("cs_busy_window", 32'(cs_ok), 32'd1);
    check_eq("rx_data", 32'(rx_c), 32'(exp_rx));
    check_eq("slave_cap", 32'(cap), 32'(data));
    if (mode != 2) check_eq("sclk_idle", 32'(sclk_c), 32'(pol));
    if (w) lpb = pol;
    else   lpa = pol;

    if (mode == 2) begin
      done_at = -1;
      for (int t = 1; t < done_t + 4; t++) begin
        @(negedge clk);
        if (done_c === 1'b1 && done_at < 0) done_at = t;
      end
      check_eq("b2b_done_time", 32'(done_at), 32'(done_t));
      check_eq("b2b_rx_data", 32'(rx_c), 32'(data));
    end
  endtask

  initial begin
    logic        bad;
    logic        w, pol, pha, lsbf, lb;
    logic [1:0]  s;
    n_checks = 0; n_fail = 0; lpa = 1'b0; lpb = 1'b0;
    start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sel = '0; tx = '0;
    which = 1'b0; loop = 1'b1; slv_miso = 1'b0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst_sclk", 32'(sclk_a), 32'd0);
    check_eq("rst_mosi", 32'(mosi_a), 32'd0);
    check_eq("rst_cs_a", 32'(cs_a), 32'h7);
    check_eq("rst_cs_b", 32'(cs_b), 32'hF);
    check_eq("rst_busy", 32'(busy_a), 32'd0);
    check_eq("rst_done", 32'(done_a), 32'd0);
    check_eq("rst_rx", 32'(rx_a), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h00A5, 16'h0000, 1'b1, 0);
    check_eq("cs_sel1_idle", 32'(cs_a), 32'h7);
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 2'd2, 16'h00C3, 16'h003C, 1'b0, 0);
    run_xfer(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 16'h00C3, 16'h003C, 1'b0, 0);
    run_xfer(1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 16'hBEEF, 16'h0000, 1'b1, 0);
    run_xfer(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 16'h005A, 16'h0096, 1'b0, 1);

    @(negedge clk);
    which = 1'b0; sel = 2'd3; tx = 16'h00FF; start = 1'b1; bad = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (cs_a !== 3'b111 || busy_a !== 1'b0 || done_a !== 1'b0 || sclk_a !== lpa) bad = 1'b1;
    end
    start = 1'b0;
    check_eq("sel_oob_ignored", 32'(bad), 32'd0);

    run_xfer(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 16'h0071, 16'h0000, 1'b1, 2);

    @(negedge clk);
    which = 1'b0; cpol = 1'b1; cpha = 1'b0; lsb_first = 1'b0; sel = 2'd0;
    tx = 16'h0081; loop = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_eq("abort_sclk", 32'(sclk_a), 32'd0);
    check_eq("abort_mosi", 32'(mosi_a), 32'd0);
    check_eq("abort_cs", 32'(cs_a), 32'h7);
    check_eq("abort_busy", 32'(busy_a), 32'd0);
    check_eq("abort_done", 32'(done_a), 32'd0);
    check_eq("abort_rx", 32'(rx_a), 32'd0);
    lpa = 1'b0; lpb = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done_a !== 1'b0) bad = 1'b1;
    end
    check_eq("abort_no_done", 32'(bad), 32'd0);
    run_xfer(1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'h0036, 16'h0000, 1'b1, 0);

    for (int i = 0; i < 10; i++) begin
      w    = 1'($urandom);
      pol  = 1'($urandom);
      pha  = 1'($urandom);
      lsbf = 1'($urandom);
      lb   = 1'($urandom);
      s    = w ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
      run_xfer(w, pol, pha, lsbf, s, 16'($urandom), 16'($urandom), lb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
